// File: rtl/seg7_glyph_pkg.sv
// Segment constants and glyph-code mapping for the 7-seg message path.
// Patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg7_glyph_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_W     = 8'hC1;  // drawn as a "U"
    localparam logic [7:0] SEG_R     = 8'hAF;  // lowercase r
    localparam logic [7:0] SEG_D     = 8'hA1;  // lowercase d

    localparam logic [2:0] CODE_BLANK = 3'd0;
    localparam logic [2:0] CODE_H     = 3'd1;
    localparam logic [2:0] CODE_E     = 3'd2;
    localparam logic [2:0] CODE_L     = 3'd3;
    localparam logic [2:0] CODE_O     = 3'd4;
    localparam logic [2:0] CODE_W     = 3'd5;
    localparam logic [2:0] CODE_R     = 3'd6;
    localparam logic [2:0] CODE_D     = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wr_state_e;

    function automatic logic [7:0] code_to_seg(input logic [2:0] code);
        logic [7:0] seg;
        case (code)
            CODE_H:  seg = SEG_H;
            CODE_E:  seg = SEG_E;
            CODE_L:  seg = SEG_L;
            CODE_O:  seg = SEG_O;
            CODE_W:  seg = SEG_W;
            CODE_R:  seg = SEG_R;
            CODE_D:  seg = SEG_D;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        db_d    = db_q;
        cnt_d   = '0;
        // Level must differ from the debounced value for DEBOUNCE_CYCLES
        // consecutive cycles before it is accepted.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = db_q & ~db_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/msg_entry_writer.sv
// Message buffer writer: appends debounced glyph commits, sweeps the buffer
// to BLANK on clear/reset, and serves a registered read port to the scroller.
import seg7_glyph_pkg::*;

module msg_entry_writer #(
    parameter int MAX_LEN         = 20,
    parameter int ADDR_W          = 5,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst_n,
    input  logic [2:0]        char_code,
    input  logic              key_commit_n,
    input  logic              key_clear_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   msg_len,
    output logic              full,
    output logic              busy,
    output logic              wr_pulse,
    output logic [7:0]        preview
);

    logic commit_ev, clear_ev;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_db (
        .clk   (MAX10_CLK1_50),
        .rst_n (rst_n),
        .key_n (key_commit_n),
        .press (commit_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (MAX10_CLK1_50),
        .rst_n (rst_n),
        .key_n (key_clear_n),
        .press (clear_ev)
    );

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W:0]   msg_len_q, msg_len_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        mem [MAX_LEN];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              full_c;

    assign full_c = (msg_len_q == (ADDR_W+1)'(MAX_LEN));

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        msg_len_d = msg_len_q;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = SEG_BLANK;
        wr_pulse  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clear_ev) begin
                    clr_ptr_d = '0;
                end else if (clr_ptr_q == ADDR_W'(MAX_LEN - 1)) begin
                    clr_ptr_d = '0;
                    msg_len_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                // Clear takes priority over a commit arriving in the same cycle.
                if (clear_ev) begin
                    clr_ptr_d = '0;
                    state_d   = ST_CLEAR;
                end else if (commit_ev && !full_c) begin
                    mem_we    = 1'b1;
                    mem_waddr = msg_len_q[ADDR_W-1:0];
                    mem_wdata = code_to_seg(char_code);
                    msg_len_d = msg_len_q + (ADDR_W+1)'(1);
                    wr_pulse  = 1'b1;
                end
            end
        endcase
    end

    // Read compares against the pre-write length and returns pre-write data.
    always_comb begin
        rd_data_d = SEG_BLANK;
        if ({1'b0, rd_addr} < msg_len_q) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            msg_len_q <= '0;
            rd_data_q <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            msg_len_q <= msg_len_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data = rd_data_q;
    assign msg_len = msg_len_q;
    assign full    = full_c;
    assign busy    = (state_q == ST_CLEAR);
    assign preview = code_to_seg(char_code);

endmodule

// File: tb/tb_msg_entry_writer.sv
// Directed bench for msg_entry_writer with a short debounce window.
module tb_msg_entry_writer;

    localparam int MAX_LEN = 20;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        char_code = 3'd0;
    logic              key_commit_n = 1'b1;
    logic              key_clear_n = 1'b1;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic [ADDR_W:0]   msg_len;
    logic              full, busy, wr_pulse;
    logic [7:0]        preview;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    msg_entry_writer #(
        .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .DEBOUNCE_CYCLES(4)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .char_code     (char_code),
        .key_commit_n  (key_commit_n),
        .key_clear_n   (key_clear_n),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .msg_len       (msg_len),
        .full          (full),
        .busy          (busy),
        .wr_pulse      (wr_pulse),
        .preview       (preview)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (rst_n && wr_pulse) pulses++;

    task automatic commit(input logic [2:0] code);
        char_code = code;
        key_commit_n = 1'b0;
        repeat (10) @(negedge clk);
        key_commit_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic read_at(input int a, output logic [7:0] d);
        rd_addr = ADDR_W'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] d;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || msg_len !== 6'd0 || rd_data !== 8'hFF || wr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: busy=%b len=%0d rd=%h wp=%b, want 1 0 FF 0", busy, msg_len, rd_data, wr_pulse);
        end
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != MAX_LEN) begin
            errors++;
            $display("FAIL reset_sweep_len: busy cycles=%0d want %0d", n, MAX_LEN);
        end
        checks++;
        if (msg_len !== 6'd0) begin
            errors++;
            $display("FAIL reset_len: got %0d want 0", msg_len);
        end
        for (int a = 0; a < 32; a++) begin
            read_at(a, d);
            checks++;
            if (d !== 8'hFF) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h want FF", a, d);
            end
        end
    endtask

    task automatic test_commit_basic();
        logic [7:0] exp [5] = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0};
        logic [2:0] codes [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
        logic [7:0] d;
        int p0 = pulses;
        for (int i = 0; i < 5; i++) commit(codes[i]);
        checks++;
        if (msg_len !== 6'd5 || pulses - p0 != 5) begin
            errors++;
            $display("FAIL commit_len: len=%0d pulses=%0d want 5 5", msg_len, pulses - p0);
        end
        for (int a = 0; a < 6; a++) begin
            read_at(a, d);
            checks++;
            if (d !== ((a < 5) ? exp[a] : 8'hFF)) begin
                errors++;
                $display("FAIL commit_read[%0d]: got %h want %h", a, d, (a < 5) ? exp[a] : 8'hFF);
            end
        end
        char_code = 3'd3;
        #1;
        checks++;
        if (preview !== 8'hC7) begin
            errors++;
            $display("FAIL preview_L: got %h want C7", preview);
        end
        char_code = 3'd0;
        #1;
        checks++;
        if (preview !== 8'hFF) begin
            errors++;
            $display("FAIL preview_blank: got %h want FF", preview);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] d;
        int p0 = pulses;
        char_code = 3'd5;
        for (int i = 0; i < 10; i++) begin
            key_commit_n = ~key_commit_n;
            repeat (2) @(negedge clk);
        end
        key_commit_n = 1'b0;
        repeat (10) @(negedge clk);
        key_commit_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (msg_len !== 6'd6 || pulses - p0 != 1) begin
            errors++;
            $display("FAIL bounce_one: len=%0d pulses=%0d want 6 1", msg_len, pulses - p0);
        end
        read_at(5, d);
        checks++;
        if (d !== 8'hC1) begin
            errors++;
            $display("FAIL bounce_read: got %h want C1", d);
        end
        p0 = pulses;
        key_commit_n = 1'b0;
        repeat (3) @(negedge clk);
        key_commit_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (msg_len !== 6'd6 || pulses - p0 != 0) begin
            errors++;
            $display("FAIL glitch_zero: len=%0d pulses=%0d want 6 0", msg_len, pulses - p0);
        end
    endtask

    task automatic test_fill();
        logic [7:0] d;
        int p0;
        for (int i = 6; i < MAX_LEN; i++) commit((i == MAX_LEN - 1) ? 3'd7 : 3'd6);
        checks++;
        if (full !== 1'b1 || msg_len !== 6'd20) begin
            errors++;
            $display("FAIL fill_full: full=%b len=%0d want 1 20", full, msg_len);
        end
        p0 = pulses;
        commit(3'd1);
        checks++;
        if (msg_len !== 6'd20 || pulses - p0 != 0 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_drop: len=%0d pulses=%0d full=%b want 20 0 1", msg_len, pulses - p0, full);
        end
        read_at(19, d);
        checks++;
        if (d !== 8'hA1) begin
            errors++;
            $display("FAIL fill_mem19: got %h want A1", d);
        end
        read_at(10, d);
        checks++;
        if (d !== 8'hAF) begin
            errors++;
            $display("FAIL fill_mem10: got %h want AF", d);
        end
    endtask

    task automatic test_clear();
        int n, bad, p0;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 7; i++) commit(3'd2);
        p0 = pulses;
        key_clear_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) break;
            @(negedge clk);
        end
        key_commit_n = 1'b0;
        n = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            if (msg_len !== 6'd7) bad++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != MAX_LEN || bad != 0) begin
            errors++;
            $display("FAIL clear_sweep: busy=%0d badlen=%0d want %0d 0", n, bad, MAX_LEN);
        end
        key_commit_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (msg_len !== 6'd0 || pulses - p0 != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_drop: len=%0d pulses=%0d busy=%b want 0 0 0", msg_len, pulses - p0, busy);
        end
        read_at(3, d);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL clear_read: got %h want FF", d);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        logic [7:0] d;
        commit(3'd1);
        commit(3'd2);
        p0 = pulses;
        char_code = 3'd4;
        key_commit_n = 1'b0;
        key_clear_n = 1'b0;
        repeat (10) @(negedge clk);
        key_commit_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (msg_len !== 6'd0 || pulses - p0 != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_clear_wins: len=%0d pulses=%0d busy=%b want 0 0 0", msg_len, pulses - p0, busy);
        end
        read_at(0, d);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL simul_read: got %h want FF", d);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        for (int i = 0; i < 12; i++) commit(3'd4);
        rd_addr = 5'd11;
        @(negedge clk);
        checks++;
        if (rd_data !== 8'hC0 || msg_len !== 6'd12) begin
            errors++;
            $display("FAIL midrst_pre: rd=%h len=%0d want C0 12", rd_data, msg_len);
        end
        key_clear_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) break;
            @(negedge clk);
        end
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        key_clear_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || msg_len !== 6'd0 || rd_data !== 8'hFF || wr_pulse !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: busy=%b len=%0d rd=%h wp=%b want 1 0 FF 0", busy, msg_len, rd_data, wr_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != MAX_LEN || msg_len !== 6'd0) begin
            errors++;
            $display("FAIL midrst_sweep: busy=%0d len=%0d want %0d 0", n, msg_len, MAX_LEN);
        end
    endtask

    initial begin
        test_reset();
        test_commit_basic();
        test_bounce();
        test_fill();
        test_clear();
        test_simultaneous();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
